// File: rtl/out_port_uart_tx.sv
// Serial output stage for the KGP_RISC out port. Each word the processor writes
// is queued in a small FIFO and then sent as four 8N1 UART frames, low byte first.
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 out_val,
  input  logic                        out_we,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BW       = $clog2(CLKS_PER_BIT);
  localparam int ONE_I    = 1;
  localparam int ZERO_I   = 0;
  localparam int BLAST_I  = CLKS_PER_BIT - 1;

  localparam logic [BW-1:0] BAUD_LAST = BLAST_I[BW-1:0];
  localparam logic [BW-1:0] BAUD_ZERO = ZERO_I[BW-1:0];
  localparam logic [BW-1:0] BAUD_ONE  = ONE_I[BW-1:0];
  localparam logic [AW:0]   CNT_DEPTH = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ZERO  = ZERO_I[AW:0];
  localparam logic [AW:0]   CNT_ONE   = ONE_I[AW:0];
  localparam logic [AW-1:0] PTR_ZERO  = ZERO_I[AW-1:0];
  localparam logic [AW-1:0] PTR_ONE   = ONE_I[AW-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [1:0]    byte_idx_q;
  logic [31:0]   shift_q;
  logic          tx_q;
  logic          busy_q;
  logic          ovf_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          baud_end_s;
  logic          word_end_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          goes_idle_s;
  logic          busy_d;
  logic [31:0]   rdata_s;
  logic [7:0]    cur_byte_s;
  logic [2:0]    next_bit_idx_s;

  // FIFO handshake, next occupancy and the next-cycle busy indication
  always_comb begin
    fifo_empty_s   = (count_q == CNT_ZERO);
    fifo_full_s    = (count_q == CNT_DEPTH);
    baud_end_s     = (baud_q == BAUD_LAST);
    word_end_s     = (state_q == S_STOP) && baud_end_s && (byte_idx_q == 2'd3);
    pop_s          = !fifo_empty_s && ((state_q == S_IDLE) || word_end_s);
    // A pop on the same edge frees a slot, so a full FIFO still accepts the word
    push_s         = out_we && (!fifo_full_s || pop_s);
    drop_s         = out_we && fifo_full_s && !pop_s;
    goes_idle_s    = !pop_s && ((state_q == S_IDLE) || word_end_s);
    rdata_s        = mem_q[rd_ptr_q];
    cur_byte_s     = shift_q[7:0];
    next_bit_idx_s = bit_idx_q + 3'd1;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    busy_d = !goes_idle_s || (count_d != CNT_ZERO);
  end

  // FIFO word storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= out_val;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (drop_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, four bytes per word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= BAUD_ZERO;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= BAUD_ZERO;
          if (pop_s) begin
            shift_q    <= rdata_s;
            byte_idx_q <= 2'd0;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (baud_end_s) begin
            baud_q    <= BAUD_ZERO;
            bit_idx_q <= 3'd0;
            tx_q      <= cur_byte_s[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_end_s) begin
            baud_q <= BAUD_ZERO;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= next_bit_idx_s;
              tx_q      <= cur_byte_s[next_bit_idx_s];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (baud_end_s) begin
            baud_q <= BAUD_ZERO;
            if (byte_idx_q != 2'd3) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              shift_q    <= {8'd0, shift_q[31:8]};
              tx_q       <= 1'b0;
              state_q    <= S_START;
            end else if (pop_s) begin
              // Back-to-back words: next start bit follows the stop bit directly
              shift_q    <= rdata_s;
              byte_idx_q <= 2'd0;
              tx_q       <= 1'b0;
              state_q    <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= BAUD_ZERO;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule
